// File: rtl/fcc_pkg.sv
// Shared definitions for the FC-layer BRAM controllers.
// Holds the reader FSM state type and default geometry.
package fcc_pkg;

    localparam int DEF_DWIDTH   = 16;
    localparam int DEF_AWIDTH   = 12;
    localparam int DEF_MEM_SIZE = 3840;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid FIFO between BRAM read data and the stream port.
// Head stays stable while no pop is taken.
module rd_skid_fifo #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] head,
    output logic [1:0]        count
);

    logic [DWIDTH-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;

    assign head = mem[rd_ptr];

    // storage write; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // the issue logic upstream must never overrun the two entries
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && count == 2'd2))
                else $error("rd_skid_fifo overflow");
        end
    end

endmodule

// File: rtl/dpbram_stream_reader.sv
// Reads NUM words from one BRAM port starting at BASE and streams them
// out through a skid FIFO; issue is throttled so the FIFO never overflows.
module dpbram_stream_reader
    import fcc_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int LWIDTH   = DEF_AWIDTH + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    input  logic [LWIDTH-1:0] num_i,
    output logic              idle_o,
    output logic              running_o,
    output logic              done_o,
    output logic [AWIDTH-1:0] addr0_o,
    output logic              ce0_o,
    output logic              we0_o,
    output logic [DWIDTH-1:0] d0_o,
    input  logic [DWIDTH-1:0] q0_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DWIDTH-1:0] m_data_o
);

    localparam logic [AWIDTH:0] MEM_LIM = (AWIDTH + 1)'(MEM_SIZE);

    rd_state_t         state;
    logic [AWIDTH-1:0] base;
    logic [LWIDTH-1:0] num;
    logic [LWIDTH-1:0] issued;
    logic [LWIDTH-1:0] beats;
    logic              inflight;
    logic [1:0]        count;
    logic              pop;
    logic [2:0]        occ;
    logic [AWIDTH:0]   sum;
    logic [AWIDTH:0]   wrapped;

    assign we0_o     = 1'b0;
    assign d0_o      = '0;
    assign m_valid_o = (count != 2'd0);
    assign pop       = m_valid_o & m_ready_i;

    // words held or on their way, net of the one leaving this cycle
    assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign ce0_o = (state == S_RUN) && (issued < num) && (occ < 3'd2);

    // address = base + issued, folded back into the BRAM depth
    assign sum     = {1'b0, base} + issued[AWIDTH:0];
    assign wrapped = (sum >= MEM_LIM) ? (sum - MEM_LIM) : sum;
    assign addr0_o = wrapped[AWIDTH-1:0];

    rd_skid_fifo #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight),
        .pop     (pop),
        .din     (q0_i),
        .head    (m_data_o),
        .count   (count)
    );

    // control FSM with counters, inflight flag and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idle_o    <= 1'b1;
            running_o <= 1'b0;
            done_o    <= 1'b0;
            base      <= '0;
            num       <= '0;
            issued    <= '0;
            beats     <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= ce0_o;
            done_o   <= 1'b0;
            if (ce0_o) issued <= issued + LWIDTH'(1);
            if (pop)   beats  <= beats + LWIDTH'(1);
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        base   <= base_addr_i;
                        num    <= num_i;
                        issued <= '0;
                        beats  <= '0;
                        idle_o <= 1'b0;
                        if (num_i == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            running_o <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pop && beats == num - LWIDTH'(1)) begin
                        state     <= S_DONE;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    idle_o <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    idle_o    <= 1'b1;
                    running_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpbram_stream_reader.sv
// Scoreboard bench for dpbram_stream_reader with a behavioural BRAM.
// Expected words/addresses are queued at start; a monitor pops them.
module tb_dpbram_stream_reader;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int MS = 3840;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] num = '0;
    logic          idle, running, done, ce0, we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0 = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;

    logic [DW-1:0] ram [MS];

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int rmode = 0;

    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    int issues = 0;
    int pops = 0;
    int first_valid_cyc = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;
    bit hold_pending = 0;
    logic [DW-1:0] hold_data;
    bit mp;

    dpbram_stream_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .num_i       (num),
        .idle_o      (idle),
        .running_o   (running),
        .done_o      (done),
        .addr0_o     (addr0),
        .ce0_o       (ce0),
        .we0_o       (we0),
        .d0_o        (d0),
        .q0_i        (q0),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read BRAM model
    always @(posedge clk) begin
        if (ce0) q0 <= ram[addr0];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // monitor: issue addresses, occupancy bound, beat data, hold stability
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pending = 0;
        end else begin
            mp = m_valid && m_ready;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pending) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_data);
            end
            hold_pending = m_valid && !m_ready;
            hold_data = m_data;
            if (ce0) begin
                chk("occupancy_lt2", ((issues - pops - (mp ? 1 : 0)) < 2), 1);
                if (addr_q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL extra_issue: got addr %0d required no issue",
                             addr0);
                end else begin
                    chk("addr", addr0, addr_q.pop_front());
                end
                issues++;
            end
            if (mp) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL extra_beat: got %0d required no beat", m_data);
                end else begin
                    chk("data", m_data, exp_q.pop_front());
                end
                if (pops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pops++;
            end
        end
    end

    // consumer ready pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        addr_q.delete();
        issues = 0;
        pops = 0;
        first_valid_cyc = -1;
        first_pop_cyc = -1;
        last_pop_cyc = -1;
    endtask

    task automatic start_xfer(input int b, input int n, output int kedge);
        clear_sb();
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(32'((b + i) % MS));
            exp_q.push_back(32'(ram[(b + i) % MS]));
        end
        start = 1'b1;
        base_addr = AW'(b);
        num = LW'(n);
        tick();
        start = 1'b0;
        kedge = cyc;
    endtask

    task automatic wait_done(input int kedge, input int n);
        int dc;
        bit busy;
        dc = -1;
        busy = 0;
        for (int i = 0; i < 3000 && dc < 0; i++) begin
            @(negedge clk);
            busy = busy | m_valid | ce0;
            if (done) dc = cyc;
        end
        if (dc < 0) begin
            vectors++;
            errs++;
            $display("FAIL done_timeout: got no done_o required a pulse");
        end else begin
            if (n == 0) begin
                chk("done_lat_num0", ((dc - kedge) <= 1), 1);
                chk("num0_quiet", busy, 0);
            end else begin
                chk("done_after_last", dc, last_pop_cyc + 1);
            end
            chk("all_beats", exp_q.size(), 0);
            chk("all_issues", addr_q.size(), 0);
            chk("beat_count", pops, n);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_after", idle, 1);
        end
        tick();
    endtask

    initial begin
        int k;
        int b;
        int n;
        bit reached;

        for (int i = 0; i < MS; i++) ram[i] = DW'(i);

        // reset state
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_idle", idle, 1);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_ce0", ce0, 0);
        chk("rst_addr0", addr0, 0);
        chk("rst_valid", m_valid, 0);
        chk("we0_zero", we0, 0);
        chk("d0_zero", d0, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // basic streaming, full throughput
        rmode = 0;
        start_xfer(0, 8, k);
        @(negedge clk);
        chk("run_running", running, 1);
        chk("run_idle", idle, 0);
        wait_done(k, 8);
        chk("first_valid_lat", first_valid_cyc - k, 2);
        chk("consecutive", last_pop_cyc - first_pop_cyc, 7);

        // toggling backpressure
        rmode = 1;
        start_xfer(0, 8, k);
        wait_done(k, 8);

        // address wrap at the end of the BRAM
        rmode = 0;
        start_xfer(3838, 4, k);
        wait_done(k, 4);

        // zero-length transfer
        start_xfer(17, 0, k);
        wait_done(k, 0);

        // start pulsed while running is ignored
        rmode = 2;
        start_xfer(40, 10, k);
        repeat (3) tick();
        start = 1'b1;
        base_addr = AW'(500);
        num = LW'(3);
        tick();
        start = 1'b0;
        wait_done(k, 10);

        // reset mid-transfer after three beats
        rmode = 0;
        start_xfer(200, 8, k);
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            if (pops >= 3) reached = 1;
            else tick();
        end
        if (!reached) begin
            vectors++;
            errs++;
            $display("FAIL mid_reset_wait: got %0d beats required 3", pops);
        end
        reset_n = 1'b0;
        clear_sb();
        tick();
        @(negedge clk);
        chk("abort_valid", m_valid, 0);
        chk("abort_ce0", ce0, 0);
        chk("abort_idle", idle, 1);
        tick();
        reset_n = 1'b1;
        tick();
        rmode = 2;
        start_xfer(100, 5, k);
        wait_done(k, 5);

        // randomized contents, bases, lengths and backpressure
        for (int i = 0; i < MS; i++) ram[i] = DW'($urandom);
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                b = MS - 5;
                n = 20;
            end else begin
                b = $urandom_range(0, MS - 1);
                n = $urandom_range(1, 40);
            end
            rmode = (t % 3 == 0) ? 0 : 2;
            start_xfer(b, n, k);
            wait_done(k, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
